// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - CPU request/response and data-memory bus of the memory access unit.
interface mem_access_unit_if #(
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [1:0]                req_size;
  logic [ADDR_BIT_WIDTH-1:0] req_addr;
  logic [DATA_BIT_WIDTH-1:0] req_wdata;
  logic                      resp_valid;
  logic                      resp_err;
  logic [DATA_BIT_WIDTH-1:0] resp_rdata;
  logic                      mem_wrtEn;
  logic [ADDR_BIT_WIDTH-1:0] mem_addr;
  logic [DATA_BIT_WIDTH-1:0] mem_dIn;
  logic [DATA_BIT_WIDTH-1:0] mem_dOut;

  // The unit is the target of the request bus, so it takes the slave view.
  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, mem_dOut,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_wrtEn, mem_addr, mem_dIn
  );

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, mem_dOut,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_wrtEn, mem_addr, mem_dIn
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator for data RAM and memory-mapped I/O.
// MAU_SUBWORD_EN enables byte/half loads and read-modify-write byte/half RAM stores.
module mem_access_unit #(
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32,
  parameter int IO_ADDR_BIT    = 29
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD0  = 3'd1;
  localparam logic [2:0] RD1  = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] RESP = 3'd4;
`ifdef MAU_SUBWORD_EN
  localparam logic [2:0] MRG  = 3'd5;
`endif

  logic [2:0]                state;
  logic                      resp_valid;
  logic                      resp_err;
  logic [DATA_BIT_WIDTH-1:0] resp_rdata;
  logic                      mem_wrtEn;
  logic [ADDR_BIT_WIDTH-1:0] mem_addr;
  logic [DATA_BIT_WIDTH-1:0] mem_dIn;
  logic                      illegal;

`ifdef MAU_SUBWORD_EN
  logic                      lat_we;
  logic [1:0]                lat_size;
  logic [1:0]                lat_lane;
  logic [DATA_BIT_WIDTH-1:0] lat_wdata;
  logic [DATA_BIT_WIDTH-1:0] rd_word;

  function automatic logic [DATA_BIT_WIDTH-1:0] extract(
    input logic [DATA_BIT_WIDTH-1:0] w, input logic [1:0] sz, input logic [1:0] ln);
    logic [DATA_BIT_WIDTH-1:0] r;
    r = '0;
    case (sz)
      2'b00:   r[7:0]  = w[{ln, 3'b000} +: 8];
      2'b01:   r[15:0] = w[{ln[1], 4'b0000} +: 16];
      default: r       = w;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_BIT_WIDTH-1:0] merge(
    input logic [DATA_BIT_WIDTH-1:0] w, input logic [DATA_BIT_WIDTH-1:0] d,
    input logic [1:0] sz, input logic [1:0] ln);
    logic [DATA_BIT_WIDTH-1:0] r;
    r = w;
    case (sz)
      2'b00:   r[{ln, 3'b000} +: 8]     = d[7:0];
      2'b01:   r[{ln[1], 4'b0000} +: 16] = d[15:0];
      default: r                         = d;
    endcase
    return r;
  endfunction
`endif

  always_comb begin
    illegal = 1'b0;
    case (bus.req_size)
      2'b00:   illegal = 1'b0;
      2'b01:   illegal = bus.req_addr[0];
      2'b10:   illegal = |bus.req_addr[1:0];
      default: illegal = 1'b1;
    endcase
    // Sub-word stores are read-modify-write, which must never touch I/O registers.
    if (bus.req_we && bus.req_size != 2'b10 && bus.req_addr[IO_ADDR_BIT])
      illegal = 1'b1;
`ifndef MAU_SUBWORD_EN
    if (bus.req_size != 2'b10)
      illegal = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_wrtEn  <= 1'b0;
      mem_addr   <= '0;
      mem_dIn    <= '0;
`ifdef MAU_SUBWORD_EN
      lat_we     <= 1'b0;
      lat_size   <= 2'b00;
      lat_lane   <= 2'b00;
      lat_wdata  <= '0;
      rd_word    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (illegal) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else begin
              mem_addr <= {bus.req_addr[ADDR_BIT_WIDTH-1:2], 2'b00};
`ifdef MAU_SUBWORD_EN
              lat_we    <= bus.req_we;
              lat_size  <= bus.req_size;
              lat_lane  <= bus.req_addr[1:0];
              lat_wdata <= bus.req_wdata;
`endif
              if (bus.req_we && bus.req_size == 2'b10) begin
                mem_dIn   <= bus.req_wdata;
                mem_wrtEn <= 1'b1;
                state     <= WR;
              end else begin
                state <= RD0;
              end
            end
          end
        end
        // RD0 only holds the address: RAM registers it on the negedge, I/O latches on the next posedge.
        RD0: state <= RD1;
        RD1: begin
`ifdef MAU_SUBWORD_EN
          if (lat_we) begin
            rd_word <= bus.mem_dOut;
            state   <= MRG;
          end else begin
            resp_rdata <= extract(bus.mem_dOut, lat_size, lat_lane);
            resp_valid <= 1'b1;
            state      <= RESP;
          end
`else
          resp_rdata <= bus.mem_dOut;
          resp_valid <= 1'b1;
          state      <= RESP;
`endif
        end
`ifdef MAU_SUBWORD_EN
        MRG: begin
          mem_dIn   <= merge(rd_word, lat_wdata, lat_size, lat_lane);
          mem_wrtEn <= 1'b1;
          state     <= WR;
        end
`endif
        WR: begin
          mem_wrtEn  <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: begin
          mem_wrtEn <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid;
  assign bus.resp_err   = resp_err;
  assign bus.resp_rdata = resp_rdata;
  assign bus.mem_wrtEn  = mem_wrtEn;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_dIn    = mem_dIn;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed bench for mem_access_unit with a negedge RAM and posedge SW/KEY model.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  sw = 10'h2A5;
  logic [3:0]  key = 4'b1110;
  logic [31:0] ram [0:255];
  logic [31:0] ram_q = '0;
  logic [31:0] io_q = '0;
  int          wr_total = 0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  int          n_checks = 0;
  int          n_errors = 0;

  mem_access_unit_if #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32)) bus ();

  mem_access_unit #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32), .IO_ADDR_BIT(29)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) ram_q <= ram[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    io_q <= bus.mem_addr[2] ? {22'b0, sw} : {28'b0, ~key};
    if (bus.mem_wrtEn) begin
      wr_total <= wr_total + 1;
      wr_addr  <= bus.mem_addr;
      wr_data  <= bus.mem_dIn;
      if (!bus.mem_addr[29]) ram[bus.mem_addr[9:2]] <= bus.mem_dIn;
    end
  end

  assign bus.mem_dOut = bus.mem_addr[29] ? io_q : ram_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat);
    int  k;
    bit  done;
    k = 0;
    @(negedge clk);
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    k = 0;
    done = 1'b0;
    while (!done && k < 20) begin
      @(negedge clk);
      if (bus.resp_valid) done = 1'b1;
      else begin
        @(posedge clk);
        k++;
      end
    end
    if (!done) check("resp_timeout", 32'd0, 32'd1);
    lat   = done ? k + 1 : -1;
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] addr_before;
    logic [31:0] ram_before;
    logic [31:0] exp_40;
    logic        er;
    int          lat;
    int          wr_before;
    int          resp_seen;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready",  {31'b0, bus.req_ready},  32'd1);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_resp_err",   {31'b0, bus.resp_err},   32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_mem_wrtEn",  {31'b0, bus.mem_wrtEn},  32'd0);
    check("rst_mem_addr",   bus.mem_addr, 32'd0);
    check("rst_mem_dIn",    bus.mem_dIn,  32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Word store 0x40 <- DEADBEEF
    wr_before = wr_total;
    run_req(1'b1, 2'b10, 32'h0000_0040, 32'hDEAD_BEEF, rd, er, lat);
    check("st_lat",    lat, 32'd2);
    check("st_err",    {31'b0, er}, 32'd0);
    check("st_rdata",  rd, 32'd0);
    check("st_wrcnt",  wr_total - wr_before, 32'd1);
    check("st_waddr",  wr_addr, 32'h0000_0040);
    check("st_wdata",  wr_data, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    check("st_pulse_end", {31'b0, bus.resp_valid}, 32'd0);
    check("st_ready_after", {31'b0, bus.req_ready}, 32'd1);

    // Word load back
    run_req(1'b0, 2'b10, 32'h0000_0040, 32'h0, rd, er, lat);
    check("ld_lat",   lat, 32'd3);
    check("ld_err",   {31'b0, er}, 32'd0);
    check("ld_rdata", rd, 32'hDEAD_BEEF);

    // Memory-mapped SW and KEY
    wr_before = wr_total;
    run_req(1'b0, 2'b10, 32'h2000_0004, 32'h0, rd, er, lat);
    check("sw_rdata", rd, 32'h0000_02A5);
    check("sw_lat",   lat, 32'd3);
    run_req(1'b0, 2'b10, 32'h2000_0000, 32'h0, rd, er, lat);
    check("key_rdata", rd, 32'h0000_0001);
    check("io_nowrite", wr_total - wr_before, 32'd0);

    // Illegal accesses: misaligned word, size 11, misaligned half, sub-word I/O store
    wr_before   = wr_total;
    addr_before = bus.mem_addr;
    run_req(1'b0, 2'b10, 32'h0000_0042, 32'h0, rd, er, lat);
    check("misal_err",   {31'b0, er}, 32'd1);
    check("misal_rdata", rd, 32'd0);
    check("misal_lat",   lat, 32'd1);
    run_req(1'b0, 2'b11, 32'h0000_0040, 32'h0, rd, er, lat);
    check("size11_err",   {31'b0, er}, 32'd1);
    check("size11_rdata", rd, 32'd0);
    run_req(1'b0, 2'b01, 32'h0000_0041, 32'h0, rd, er, lat);
    check("half_odd_err", {31'b0, er}, 32'd1);
    run_req(1'b1, 2'b00, 32'h2000_0000, 32'h55, rd, er, lat);
    check("io_byte_st_err", {31'b0, er}, 32'd1);
    check("illegal_nowrite", wr_total - wr_before, 32'd0);
    check("illegal_addr_held", bus.mem_addr, addr_before);

    // Sub-word store and loads
    wr_before = wr_total;
    run_req(1'b1, 2'b00, 32'h0000_0043, 32'h0000_0011, rd, er, lat);
`ifdef MAU_SUBWORD_EN
    check("bst_err",   {31'b0, er}, 32'd0);
    check("bst_wrcnt", wr_total - wr_before, 32'd1);
    check("bst_wdata", wr_data, 32'h11AD_BEEF);
    check("bst_waddr", wr_addr, 32'h0000_0040);
    run_req(1'b0, 2'b00, 32'h0000_0043, 32'h0, rd, er, lat);
    check("bld_rdata", rd, 32'h0000_0011);
    check("bld_lat",   lat, 32'd3);
    run_req(1'b0, 2'b00, 32'h0000_0040, 32'h0, rd, er, lat);
    check("bld0_rdata", rd, 32'h0000_00EF);
    run_req(1'b0, 2'b01, 32'h0000_0042, 32'h0, rd, er, lat);
    check("hld_rdata", rd, 32'h0000_11AD);
    exp_40 = 32'h11AD_BEEF;
`else
    check("bst_err",   {31'b0, er}, 32'd1);
    check("bst_nowrite", wr_total - wr_before, 32'd0);
    run_req(1'b0, 2'b00, 32'h0000_0043, 32'h0, rd, er, lat);
    check("bld_err",   {31'b0, er}, 32'd1);
    check("bld_rdata", rd, 32'd0);
    exp_40 = 32'hDEAD_BEEF;
`endif
    run_req(1'b0, 2'b10, 32'h0000_0040, 32'h0, rd, er, lat);
    check("word40_after_sub", rd, exp_40);

    // Reset during WR of a word store
    ram_before = ram[32];
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h0000_0080;
    bus.req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    check("wr_phase_wrtEn", {31'b0, bus.mem_wrtEn}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_async_wrtEn", {31'b0, bus.mem_wrtEn}, 32'd0);
    check("rst_async_ready", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    resp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.resp_valid) resp_seen++;
    end
    check("rst_no_resp", resp_seen, 32'd0);
    check("rst_ready_after", {31'b0, bus.req_ready}, 32'd1);
    check("rst_no_ram_write", ram[32], ram_before);
    run_req(1'b0, 2'b10, 32'h0000_0040, 32'h0, rd, er, lat);
    check("recover_rdata", rd, exp_40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
